// File: rtl/i2c_driver.sv
// Single-master I2C byte transfer engine: START, address+R/W, one data byte
// (write or read), ACK handling and STOP, on open-drain SDA/SCL.
module i2c_driver #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_or_stop,
    input  logic       read_or_write,
    input  logic [6:0] address,
    input  logic [7:0] data,
    inout  logic       sda,
    output logic       sclk,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       ack_error
);

    localparam int unsigned DIV_W = 8;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_START     = 4'd1;
    localparam logic [3:0] S_ADDR      = 4'd2;
    localparam logic [3:0] S_ADDR_ACK  = 4'd3;
    localparam logic [3:0] S_WRITE     = 4'd4;
    localparam logic [3:0] S_WRITE_ACK = 4'd5;
    localparam logic [3:0] S_READ      = 4'd6;
    localparam logic [3:0] S_READ_ACK  = 4'd7;
    localparam logic [3:0] S_STOP      = 4'd8;
    localparam logic [3:0] S_DONE      = 4'd9;

    logic [3:0]       state, state_d;
    logic [DIV_W-1:0] div_cnt, div_cnt_d;
    logic [1:0]       qtr, qtr_d;
    logic [2:0]       bit_cnt, bit_cnt_d;
    logic [7:0]       shifter, shifter_d;
    logic [6:0]       addr_q, addr_q_d;
    logic             rw_q, rw_q_d;
    logic [7:0]       data_q, data_q_d;
    logic             ack_bit, ack_bit_d;
    logic [7:0]       rd_data_d;
    logic             busy_d, done_d, ack_error_d;
    logic             sda_low, sda_low_d;
    logic             scl_low, scl_low_d;
    logic             tick, mid_high, slot_end;

    assign tick     = (div_cnt == DIV_MAX);
    assign mid_high = tick && (qtr == 2'd2);
    assign slot_end = tick && (qtr == 2'd3);

    // Open-drain pads: only ever pull low or let the pull-up win.
    assign sda  = sda_low ? 1'b0 : 1'bz;
    assign sclk = scl_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            qtr       <= '0;
            bit_cnt   <= '0;
            shifter   <= '0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            data_q    <= '0;
            ack_bit   <= 1'b0;
            rd_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_error <= 1'b0;
            sda_low   <= 1'b0;
            scl_low   <= 1'b0;
        end else begin
            state     <= state_d;
            div_cnt   <= div_cnt_d;
            qtr       <= qtr_d;
            bit_cnt   <= bit_cnt_d;
            shifter   <= shifter_d;
            addr_q    <= addr_q_d;
            rw_q      <= rw_q_d;
            data_q    <= data_q_d;
            ack_bit   <= ack_bit_d;
            rd_data   <= rd_data_d;
            busy      <= busy_d;
            done      <= done_d;
            ack_error <= ack_error_d;
            sda_low   <= sda_low_d;
            scl_low   <= scl_low_d;
        end
    end

    always_comb begin
        state_d     = state;
        div_cnt_d   = div_cnt;
        qtr_d       = qtr;
        bit_cnt_d   = bit_cnt;
        shifter_d   = shifter;
        addr_q_d    = addr_q;
        rw_q_d      = rw_q;
        data_q_d    = data_q;
        ack_bit_d   = ack_bit;
        rd_data_d   = rd_data;
        busy_d      = busy;
        done_d      = 1'b0;
        ack_error_d = ack_error;
        sda_low_d   = 1'b0;
        scl_low_d   = 1'b0;

        // Quarter-period timebase runs only inside a transaction.
        if (state != S_IDLE && state != S_DONE) begin
            if (tick) begin
                div_cnt_d = '0;
                qtr_d     = qtr + 2'd1;
            end else begin
                div_cnt_d = div_cnt + DIV_W'(1);
            end
        end

        case (state)
            S_IDLE: begin
                if (start_or_stop) begin
                    addr_q_d    = address;
                    rw_q_d      = read_or_write;
                    data_q_d    = data;
                    busy_d      = 1'b1;
                    ack_error_d = 1'b0;
                    div_cnt_d   = '0;
                    qtr_d       = 2'd0;
                    state_d     = S_START;
                end
            end
            S_START: begin
                if (slot_end) begin
                    shifter_d = {addr_q, rw_q};
                    bit_cnt_d = 3'd0;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR, S_WRITE: begin
                if (slot_end) begin
                    shifter_d = {shifter[6:0], 1'b0};
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_d = (state == S_ADDR) ? S_ADDR_ACK : S_WRITE_ACK;
                    end
                end
            end
            S_ADDR_ACK: begin
                if (mid_high) begin
                    ack_bit_d = sda;
                end
                if (slot_end) begin
                    bit_cnt_d = 3'd0;
                    if (ack_bit) begin
                        ack_error_d = 1'b1;
                        state_d     = S_STOP;
                    end else if (rw_q) begin
                        state_d = S_READ;
                    end else begin
                        shifter_d = data_q;
                        state_d   = S_WRITE;
                    end
                end
            end
            S_WRITE_ACK: begin
                if (mid_high) begin
                    ack_bit_d = sda;
                end
                if (slot_end) begin
                    ack_error_d = ack_bit;
                    state_d     = S_STOP;
                end
            end
            S_READ: begin
                if (mid_high) begin
                    rd_data_d = {rd_data[6:0], sda};
                end
                if (slot_end) begin
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_d = S_READ_ACK;
                    end
                end
            end
            S_READ_ACK: begin
                if (slot_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (slot_end) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Line levels for the coming cycle, decoded from the next state/quarter.
        case (state_d)
            S_START: begin
                scl_low_d = (qtr_d == 2'd3);
                sda_low_d = (qtr_d >= 2'd2);
            end
            S_ADDR, S_WRITE: begin
                scl_low_d = (qtr_d < 2'd2);
                sda_low_d = ~shifter_d[7];
            end
            S_ADDR_ACK, S_WRITE_ACK, S_READ, S_READ_ACK: begin
                scl_low_d = (qtr_d < 2'd2);
            end
            S_STOP: begin
                scl_low_d = (qtr_d < 2'd2);
                sda_low_d = (qtr_d != 2'd3);
            end
            default: begin
                scl_low_d = 1'b0;
                sda_low_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_driver.sv
// Scoreboard bench for i2c_driver: bus monitor, simple slave model at address 27,
// expected transactions queued at request time and checked on each done pulse.
module tb_i2c_driver;

    localparam int unsigned CLK_DIV = 3;
    localparam int FULL_CYC = 80 * CLK_DIV;
    localparam int NACK_CYC = 44 * CLK_DIV;
    localparam logic [6:0] SLAVE_ADDR = 7'd27;

    typedef struct {
        logic [7:0] addr_byte;
        logic [7:0] data_byte;
        bit         is_read;
        bit         nack_addr;
        logic       ack_err;
        int         cycles;
        int         rises;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_or_stop = 1'b0;
    logic       read_or_write = 1'b0;
    logic [6:0] address = '0;
    logic [7:0] data = '0;
    logic [7:0] rd_data;
    logic       busy, done, ack_error;
    wire        sda_w;
    wire        scl_w;

    pullup (sda_w);
    pullup (scl_w);

    logic       slave_low = 1'b0;
    assign sda_w = slave_low ? 1'b0 : 1'bz;

    i2c_driver #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .reset(reset), .start_or_stop(start_or_stop),
        .read_or_write(read_or_write), .address(address), .data(data),
        .sda(sda_w), .sclk(scl_w), .rd_data(rd_data), .busy(busy),
        .done(done), .ack_error(ack_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t exp_q[$];
    exp_t sb_e;

    // Slave behaviour knobs
    bit         slave_present = 1'b1;
    bit         slave_data_ack = 1'b1;
    logic [7:0] slave_byte = 8'h3C;

    // Bus monitor state
    logic prev_scl = 1'b1, prev_sda = 1'b1, prev_busy = 1'b0;
    int   start_cnt = 0, seen_start = 0, stop_cnt = 0, stop_base = 0;
    int   proto_viol = 0, done_cnt = 0, t_accept = 0, bitn = 0;
    logic [7:0] obs_addr = '0, obs_data = '0;
    logic obs_ack1 = 1'b1, obs_ack2 = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // START/STOP detection and SDA-stable-while-SCL-high check.
    always @(negedge clk) begin
        if (prev_scl === 1'b1 && scl_w === 1'b1 && prev_sda !== sda_w) begin
            if (prev_sda === 1'b1 && sda_w === 1'b0) start_cnt++;
            else if (prev_sda === 1'b0 && sda_w === 1'b1) stop_cnt++;
            else proto_viol++;
        end
        prev_scl = scl_w;
        prev_sda = sda_w;
        if (busy === 1'b1 && prev_busy !== 1'b1) begin
            t_accept  = cyc;
            stop_base = stop_cnt;
        end
        prev_busy = busy;
        if (done === 1'b1) done_cnt++;
    end

    always @(posedge scl_w) begin
        if (start_cnt != seen_start) begin
            seen_start = start_cnt;
            bitn = 0;
        end
        bitn++;
        if (bitn <= 8) obs_addr = {obs_addr[6:0], sda_w};
        else if (bitn == 9) obs_ack1 = sda_w;
        else if (bitn <= 17) obs_data = {obs_data[6:0], sda_w};
        else if (bitn == 18) obs_ack2 = sda_w;
    end

    // Slave drives SDA only while SCL is low, right after each falling edge.
    always @(negedge scl_w) begin
        int nxt;
        nxt = ((start_cnt != seen_start) ? 0 : bitn) + 1;
        slave_low = 1'b0;
        if (slave_present && nxt >= 9 && nxt <= 18 && obs_addr[7:1] == SLAVE_ADDR) begin
            if (nxt == 9) slave_low = 1'b1;
            else if (nxt <= 17) begin
                if (obs_addr[0]) slave_low = !slave_byte[17 - nxt];
            end else if (!obs_addr[0]) slave_low = slave_data_ack;
        end
    end

    // Scoreboard: each done pulse consumes one expected transaction.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done got done=1 want no pending transaction");
            end else begin
                sb_e = exp_q.pop_front();
                if (obs_addr !== sb_e.addr_byte) begin
                    errors++;
                    $display("FAIL sb_addr_byte got %h want %h", obs_addr, sb_e.addr_byte);
                end
                checks++;
                if (cyc - t_accept != sb_e.cycles) begin
                    errors++;
                    $display("FAIL sb_duration got %0d want %0d", cyc - t_accept, sb_e.cycles);
                end
                checks++;
                if (ack_error !== sb_e.ack_err) begin
                    errors++;
                    $display("FAIL sb_ack_error got %b want %b", ack_error, sb_e.ack_err);
                end
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL sb_busy_at_done got %b want 0", busy);
                end
                checks++;
                if (bitn != sb_e.rises) begin
                    errors++;
                    $display("FAIL sb_scl_pulses got %0d want %0d", bitn, sb_e.rises);
                end
                checks++;
                if (stop_cnt - stop_base != 1) begin
                    errors++;
                    $display("FAIL sb_stop_count got %0d want 1", stop_cnt - stop_base);
                end
                if (!sb_e.nack_addr) begin
                    checks++;
                    if (sb_e.is_read) begin
                        if (rd_data !== sb_e.data_byte) begin
                            errors++;
                            $display("FAIL sb_rd_data got %h want %h", rd_data, sb_e.data_byte);
                        end
                        checks++;
                        if (obs_ack2 !== 1'b1) begin
                            errors++;
                            $display("FAIL sb_master_nack got %b want 1", obs_ack2);
                        end
                    end else if (obs_data !== sb_e.data_byte) begin
                        errors++;
                        $display("FAIL sb_wr_data got %h want %h", obs_data, sb_e.data_byte);
                    end
                end
            end
        end
    end

    // Issue a request; optionally wiggle inputs and re-request while busy.
    task automatic request(input logic rw, input logic [6:0] a, input logic [7:0] d,
                           input bit perturb);
        @(negedge clk);
        read_or_write = rw;
        address       = a;
        data          = d;
        start_or_stop = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (perturb) begin
            read_or_write = ~rw;
            address       = 7'h00;
            data          = 8'hFF;
            repeat (4) @(negedge clk);
        end
        start_or_stop = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 * CLK_DIV; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int d0;
        reset = 1'b0;
        #23;
        checks += 6;
        if (sda_w !== 1'b1) begin errors++; $display("FAIL rst_sda got %b want 1", sda_w); end
        if (scl_w !== 1'b1) begin errors++; $display("FAIL rst_scl got %b want 1", scl_w); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
        if (ack_error !== 1'b0) begin errors++; $display("FAIL rst_ack_error got %b want 0", ack_error); end
        if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got %h want 00", rd_data); end
        @(negedge clk);
        reset = 1'b1;
        d0 = done_cnt;
        repeat (100) @(negedge clk);
        checks += 4;
        if (sda_w !== 1'b1) begin errors++; $display("FAIL idle_sda got %b want 1", sda_w); end
        if (scl_w !== 1'b1) begin errors++; $display("FAIL idle_scl got %b want 1", scl_w); end
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
        if (done_cnt != d0) begin errors++; $display("FAIL idle_done_pulses got %0d want 0", done_cnt - d0); end
    endtask

    task automatic test_write;
        bit ok;
        exp_q.push_back('{8'h36, 8'hA5, 1'b0, 1'b0, 1'b0, FULL_CYC, 19});
        request(1'b0, SLAVE_ADDR, 8'hA5, 1'b1);
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL write_timeout got no done want done"); end
        @(negedge clk);
        checks += 2;
        if (done !== 1'b0) begin errors++; $display("FAIL write_done_width got %b want 0", done); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL write_pending got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_read;
        bit ok;
        slave_byte = 8'h3C;
        exp_q.push_back('{8'h37, 8'h3C, 1'b1, 1'b0, 1'b0, FULL_CYC, 19});
        request(1'b1, SLAVE_ADDR, 8'h00, 1'b1);
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL read_timeout got no done want done"); end
        repeat (3) @(negedge clk);
        checks++;
        if (rd_data !== 8'h3C) begin errors++; $display("FAIL read_hold got %h want 3c", rd_data); end
    endtask

    task automatic test_addr_nack;
        bit ok;
        slave_present = 1'b0;
        exp_q.push_back('{8'h36, 8'h00, 1'b0, 1'b1, 1'b1, NACK_CYC, 10});
        request(1'b0, SLAVE_ADDR, 8'h99, 1'b0);
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL nack_timeout got no done want done"); end
        repeat (2) @(negedge clk);
        checks++;
        if (ack_error !== 1'b1) begin errors++; $display("FAIL nack_held got %b want 1", ack_error); end
        slave_present = 1'b1;
    endtask

    task automatic test_data_nack;
        bit ok;
        slave_data_ack = 1'b0;
        exp_q.push_back('{8'h36, 8'h5A, 1'b0, 1'b0, 1'b1, FULL_CYC, 19});
        request(1'b0, SLAVE_ADDR, 8'h5A, 1'b0);
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL dnack_timeout got no done want done"); end
        slave_data_ack = 1'b1;
    endtask

    task automatic test_back_to_back;
        bit ok;
        exp_q.push_back('{8'h36, 8'h81, 1'b0, 1'b0, 1'b0, FULL_CYC, 19});
        exp_q.push_back('{8'h36, 8'h7E, 1'b0, 1'b0, 1'b0, FULL_CYC, 19});
        @(negedge clk);
        read_or_write = 1'b0;
        address       = SLAVE_ADDR;
        data          = 8'h81;
        start_or_stop = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data = 8'h7E;
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_first_timeout got no done want done"); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got busy=%b want 0", busy); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b want 1", busy); end
        start_or_stop = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_second_timeout got no done want done"); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int d0, s0;
        request(1'b0, SLAVE_ADDR, 8'hA5, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 200 * CLK_DIV; i++) begin
            @(negedge clk);
            if (start_cnt == seen_start && bitn == 12 && scl_w === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_reach_write got no write slot want slot 12"); end
        d0 = done_cnt;
        s0 = stop_cnt;
        #2 reset = 1'b0;
        #1;
        checks += 4;
        if (sda_w !== 1'b1) begin errors++; $display("FAIL abort_sda got %b want 1", sda_w); end
        if (scl_w !== 1'b1) begin errors++; $display("FAIL abort_scl got %b want 1", scl_w); end
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        if (rd_data !== 8'h00) begin errors++; $display("FAIL abort_rd_data got %h want 00", rd_data); end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        checks += 2;
        if (done_cnt != d0) begin errors++; $display("FAIL abort_done got %0d want 0", done_cnt - d0); end
        if (stop_cnt != s0) begin errors++; $display("FAIL abort_stop got %0d want 0", stop_cnt - s0); end
        exp_q.push_back('{8'h36, 8'h3C, 1'b0, 1'b0, 1'b0, FULL_CYC, 19});
        request(1'b0, SLAVE_ADDR, 8'h3C, 1'b0);
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL after_abort_timeout got no done want done"); end
    endtask

    task automatic test_protocol;
        @(negedge clk);
        checks += 2;
        if (proto_viol != 0) begin errors++; $display("FAIL sda_while_scl_high got %0d want 0", proto_viol); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_expected got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_data_nack();
        test_back_to_back();
        test_reset_mid();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_driver.md
I2C_DRIVER -- requirements
Module: i2c_driver

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per SCL quarter-period; legal range 1..255.
REQ-002 clk  in  1  system clock; all state changes on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 start_or_stop  in  1  transaction request, level-sampled; 1 = start a transaction when idle.
REQ-005 read_or_write  in  1  transfer direction; 1 = read, 0 = write.
REQ-006 address  in  7  target slave address (bench value 27).
REQ-007 data  in  8  byte to write.
REQ-008 sda  inout  1  I2C data line, open-drain: drives 0 or Z; pulled up externally.
REQ-009 sclk  out  1  I2C clock, open-drain: drives 0 or Z; reads high via the external pull-up.
REQ-010 rd_data  out  8  byte received in a read transaction.
REQ-011 busy  out  1  high from request acceptance until STOP completes.
REQ-012 done  out  1  one-clk pulse when a transaction ends.
REQ-013 ack_error  out  1  slave NACKed the last transaction; valid while done=1, held until the next request.

Function
REQ-014 States: IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, STOP, DONE.
REQ-015 IDLE: sda and sclk released; busy=0; when start_or_stop=1, latch address, read_or_write and data, set busy=1, go to START.
REQ-016 Requests while busy=1 are ignored; latched values stay stable for the whole transaction.
REQ-017 Bit timing: each bit slot lasts 4*CLK_DIV clocks, as four quarters: SCL low, low, high, high; SDA changes only in the first low quarter.
REQ-018 START slot: SDA falls while SCL is high; then SCL goes low.
REQ-019 ADDR: shift {address, read_or_write} MSB first (8 slots).
REQ-020 ADDR_ACK (1 slot): release SDA; sample SDA at the middle of SCL high; 0 = ACK.
REQ-021 Address NACK: set ack_error=1 and go directly to STOP; no data byte.
REQ-022 WRITE: shift the latched data byte MSB first (8 slots).
REQ-023 WRITE_ACK: sample as in ADDR_ACK; a NACK sets ack_error=1; then go to STOP.
REQ-024 READ: release SDA for 8 slots; sample at mid-SCL-high; shift MSB first into rd_data.
REQ-025 READ_ACK: release SDA (master NACK) for 1 slot; then go to STOP.
REQ-026 STOP slot: SDA driven low while SCL low; SCL released; then SDA released while SCL is high.
REQ-027 DONE: done=1 for exactly one clk, busy=0 in the same cycle; return to IDLE.
REQ-028 Duration, full transaction from the acceptance edge to the done pulse: (1 + 9 + 9 + 1) * 4 * CLK_DIV clocks.
REQ-029 Duration, address-NACK transaction: 11 * 4 * CLK_DIV clocks.
REQ-030 No clock stretching and no multi-master arbitration; the master ignores SCL held low by a slave.
REQ-031 A new request held high through the DONE cycle is accepted on the next clk in IDLE.

Reset
REQ-032 reset=0 asynchronously forces IDLE, regardless of the current state (mid-transaction included).
REQ-033 During and after reset: sda=Z, sclk=Z, busy=0, done=0, ack_error=0, rd_data=0x00, latched registers cleared.
REQ-034 An aborted transaction produces no done pulse and no STOP condition.

Verification
REQ-035 Reset then idle: after reset release with start_or_stop=0 for 100 clocks -> sda=1, sclk=1, busy=0, done never pulses.
REQ-036 Write: address=27, read_or_write=0, data=0xA5, slave ACKs -> START, bits 0x36, ACK, bits 0xA5, ACK, STOP; done after 80*CLK_DIV clocks; ack_error=0.
REQ-037 Read: address=27, read_or_write=1, slave drives 0x3C -> address byte 0x37, rd_data=0x3C, SDA released in the 9th data slot; ack_error=0.
REQ-038 Address NACK: no slave response (SDA=1) -> ack_error=1, STOP right after ADDR_ACK, done after 44*CLK_DIV clocks.
REQ-039 Protocol check: SDA never changes while SCL is high, except the START fall and the STOP rise.
REQ-040 Reset mid-transaction, during the WRITE byte -> sda and sclk released immediately, busy=0, no done; a following write completes normally.
